// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit for CDB slot 1 with an in-order store queue
// Define LSU_STORE_FWD_EN to forward uncommitted store data to loads instead of stalling them.
module load_store_unit #(
  parameter int         ADDR_W   = 8,
  parameter int         SQ_DEPTH = 4,
  parameter logic [3:0] OP_LD    = 4'd8,
  parameter logic [3:0] OP_ST    = 4'd9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [3:0]                  in_rob_idx,
  input  logic [3:0]                  in_opcode,
  input  logic [15:0]                 in_a,
  input  logic [15:0]                 in_b,
  output logic                        lsu_full,
  input  logic                        commit_valid,
  input  logic [3:0]                  commit_rob_idx,
  output logic                        cdb_valid,
  output logic [3:0]                  cdb_rob_idx,
  output logic [15:0]                 cdb_value,
  output logic [$clog2(SQ_DEPTH):0]   sq_count
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] K_NOP = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;

  logic              s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [3:0]        s0_rob_q, s0_rob_d, s1_rob_q, s1_rob_d, s2_rob_q, s2_rob_d;
  logic [1:0]        s0_kind_q, s0_kind_d, s1_kind_q, s1_kind_d;
  logic [ADDR_W-1:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;
  logic [15:0]       s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic              s2_ld_q, s2_ld_d;
  logic [15:0]       s2_val_q, s2_val_d, rd_data_q;

  logic [15:0]       mem_q [2**ADDR_W];
  logic [3:0]        sq_rob_q  [SQ_DEPTH];
  logic [ADDR_W-1:0] sq_addr_q [SQ_DEPTH];
  logic [15:0]       sq_data_q [SQ_DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [1:0]        in_kind;
  logic              accept, push, pop, ld_match, stall, s1_is_ld, s0_st, s1_st;
  logic [CW:0]       st_pending;
  logic              unused_in_a;
`ifdef LSU_STORE_FWD_EN
  logic [15:0]       fwd_data;
`endif

  assign unused_in_a = ^{1'b0, in_a};
  assign in_kind  = (in_opcode == OP_LD) ? K_LD : (in_opcode == OP_ST) ? K_ST : K_NOP;
  assign s0_st    = s0_valid_q && (s0_kind_q == K_ST);
  assign s1_st    = s1_valid_q && (s1_kind_q == K_ST);
  assign s1_is_ld = s1_valid_q && (s1_kind_q == K_LD);

  // Walk the queue oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    ld_match = 1'b0;
`ifdef LSU_STORE_FWD_EN
    fwd_data = 16'h0;
`endif
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (CW'(i) < count_q && sq_addr_q[head_q + PW'(i)] == s1_addr_q) begin
        ld_match = 1'b1;
`ifdef LSU_STORE_FWD_EN
        fwd_data = sq_data_q[head_q + PW'(i)];
`endif
      end
    end
  end

`ifdef LSU_STORE_FWD_EN
  assign stall = 1'b0;
`else
  assign stall = s1_is_ld && ld_match;
`endif

  // Stores still in S0/S1 have a queue slot reserved so a push can never overflow.
  assign st_pending = {1'b0, count_q} + {{CW{1'b0}}, s0_st} + {{CW{1'b0}}, s1_st};
  assign lsu_full   = stall || (st_pending >= (CW+1)'(SQ_DEPTH));
  assign accept     = in_valid && !lsu_full;
  assign push       = s1_st;
  assign pop        = commit_valid && (count_q != '0) && (commit_rob_idx == sq_rob_q[head_q]);

  always_comb begin
    s0_valid_d = s0_valid_q; s0_rob_d = s0_rob_q; s0_kind_d = s0_kind_q;
    s0_addr_d  = s0_addr_q;  s0_data_d = s0_data_q;
    s1_valid_d = s1_valid_q; s1_rob_d = s1_rob_q; s1_kind_d = s1_kind_q;
    s1_addr_d  = s1_addr_q;  s1_data_d = s1_data_q;
    s2_valid_d = 1'b0; s2_rob_d = s2_rob_q; s2_ld_d = s2_ld_q; s2_val_d = s2_val_q;
    if (!stall) begin
      s0_valid_d = accept;     s0_rob_d = in_rob_idx; s0_kind_d = in_kind;
      s0_addr_d  = in_a[ADDR_W-1:0]; s0_data_d = in_b;
      s1_valid_d = s0_valid_q; s1_rob_d = s0_rob_q;   s1_kind_d = s0_kind_q;
      s1_addr_d  = s0_addr_q;  s1_data_d = s0_data_q;
      s2_valid_d = s1_valid_q; s2_rob_d = s1_rob_q;   s2_ld_d = s1_is_ld;
      s2_val_d   = (s1_kind_q == K_ST) ? s1_data_q : 16'h0;
`ifdef LSU_STORE_FWD_EN
      if (s1_is_ld && ld_match) begin
        s2_ld_d  = 1'b0;
        s2_val_d = fwd_data;
      end
`endif
    end
  end

  assign head_d  = pop  ? head_q + PW'(1) : head_q;
  assign tail_d  = push ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0; s0_rob_q <= '0; s0_kind_q <= K_NOP; s0_addr_q <= '0; s0_data_q <= '0;
      s1_valid_q <= 1'b0; s1_rob_q <= '0; s1_kind_q <= K_NOP; s1_addr_q <= '0; s1_data_q <= '0;
      s2_valid_q <= 1'b0; s2_rob_q <= '0; s2_ld_q <= 1'b0;    s2_val_q <= '0;
      head_q     <= '0;   tail_q   <= '0; count_q <= '0;
    end else begin
      s0_valid_q <= s0_valid_d; s0_rob_q <= s0_rob_d; s0_kind_q <= s0_kind_d;
      s0_addr_q  <= s0_addr_d;  s0_data_q <= s0_data_d;
      s1_valid_q <= s1_valid_d; s1_rob_q <= s1_rob_d; s1_kind_q <= s1_kind_d;
      s1_addr_q  <= s1_addr_d;  s1_data_q <= s1_data_d;
      s2_valid_q <= s2_valid_d; s2_rob_q <= s2_rob_d; s2_ld_q <= s2_ld_d; s2_val_q <= s2_val_d;
      head_q     <= head_d;     tail_q   <= tail_d;   count_q <= count_d;
    end
  end

  // Queue payload and data memory carry no reset; validity lives in the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      sq_rob_q[tail_q]  <= s1_rob_q;
      sq_addr_q[tail_q] <= s1_addr_q;
      sq_data_q[tail_q] <= s1_data_q;
    end
    if (pop) mem_q[sq_addr_q[head_q]] <= sq_data_q[head_q];
    rd_data_q <= mem_q[s1_addr_q];
  end

  assign cdb_valid   = s2_valid_q;
  assign cdb_rob_idx = s2_rob_q;
  assign cdb_value   = s2_ld_q ? rd_data_q : s2_val_q;
  assign sq_count    = count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit (default or LSU_STORE_FWD_EN build)
module tb_load_store_unit;
  localparam logic [3:0] LD = 4'd8;
  localparam logic [3:0] ST = 4'd9;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, commit_valid = 1'b0;
  logic [3:0]  in_rob_idx = '0, in_opcode = '0, commit_rob_idx = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        lsu_full, cdb_valid;
  logic [3:0]  cdb_rob_idx;
  logic [15:0] cdb_value;
  logic [2:0]  sq_count;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [3:0]  rob;
    logic [15:0] val;
    int          cyc;
    bit          chk;
  } exp_t;
  exp_t sb_q[$];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rob_idx(in_rob_idx),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .lsu_full(lsu_full),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
    .sq_count(sq_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got rob=%0d value=%h, required no broadcast", cdb_rob_idx, cdb_value);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (cdb_rob_idx !== e.rob || cdb_value !== e.val || (e.chk && cyc !== e.cyc)) begin
          errors++;
          $display("FAIL cdb_result: got rob=%0d value=%h cycle=%0d, required rob=%0d value=%h cycle=%0d",
                   cdb_rob_idx, cdb_value, cyc, e.rob, e.val, e.chk ? e.cyc : cyc);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [3:0] op, input logic [3:0] rob, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_val, input bit expect_cdb,
                      input bit chk_lat);
    int   guard;
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_rob_idx = rob; in_a = a; in_b = b;
    @(negedge clk);
    guard = 0;
    while (lsu_full === 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL dispatch_timeout: rob=%0d lsu_full stayed 1, required 0", rob);
    end else if (expect_cdb) begin
      e.rob = rob; e.val = exp_val; e.cyc = cyc + 3; e.chk = chk_lat;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] rob);
    commit_valid = 1'b1; commit_rob_idx = rob;
    @(posedge clk); #1;
    commit_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (sb_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_count(input string name, input logic [2:0] exp);
    checks++;
    if (sq_count !== exp) begin
      errors++;
      $display("FAIL %s: got sq_count=%0d, required %0d", name, sq_count, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || lsu_full !== 1'b0 || sq_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: got cdb_valid=%b lsu_full=%b sq_count=%0d, required 0 0 0", cdb_valid, lsu_full, sq_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(ST, 4'd9,  16'h0050, 16'h1111, 16'h0, 1'b0, 1'b0);
    send(ST, 4'd10, 16'h0051, 16'h2222, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (cdb_valid !== 1'b1 || sq_count !== 3'd1) begin
      errors++;
      $display("FAIL reset_pre: got cdb_valid=%b sq_count=%0d, required 1 1", cdb_valid, sq_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || lsu_full !== 1'b0 || sq_count !== 3'd0 ||
        cdb_rob_idx !== 4'd0 || cdb_value !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b full=%b count=%0d rob=%0d value=%h, required all 0",
               cdb_valid, lsu_full, sq_count, cdb_rob_idx, cdb_value);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin @(posedge clk); #1; end
    check_count("reset_after_count", 3'd0);
  endtask

  task automatic test_load;
    send(ST, 4'd0, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1);
    drain("preload");
    commit(4'd0);
    send(LD, 4'd3, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b1);
    drain("load");
    send(4'd3, 4'd7, 16'h0010, 16'h7777, 16'h0000, 1'b1, 1'b1);
    drain("nop");
    check_count("nop_count", 3'd0);
  endtask

  task automatic test_store_commit;
    send(ST, 4'd5, 16'h0020, 16'h1234, 16'h1234, 1'b1, 1'b1);
    drain("store");
    check_count("store_count", 3'd1);
    commit(4'd5);
    check_count("commit_count", 3'd0);
    send(LD, 4'd6, 16'h0020, 16'h0000, 16'h1234, 1'b1, 1'b1);
    drain("load_committed");
  endtask

  task automatic test_store_fwd;
    send(ST, 4'd1, 16'h0030, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1);
    send(ST, 4'd2, 16'h0030, 16'h5555, 16'h5555, 1'b1, 1'b1);
`ifdef LSU_STORE_FWD_EN
    send(LD, 4'd4, 16'h0030, 16'h0000, 16'h5555, 1'b1, 1'b1);
    drain("fwd");
    check_count("fwd_count", 3'd2);
    commit(4'd1);
    commit(4'd2);
`else
    send(LD, 4'd4, 16'h0030, 16'h0000, 16'h5555, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (lsu_full !== 1'b1 || sb_q.size() != 1) begin
      errors++;
      $display("FAIL stall_hold: got lsu_full=%b pending=%0d, required 1 1", lsu_full, sb_q.size());
    end
    commit(4'd1);
    checks++;
    if (lsu_full !== 1'b1 || sb_q.size() != 1) begin
      errors++;
      $display("FAIL stall_one_left: got lsu_full=%b pending=%0d, required 1 1", lsu_full, sb_q.size());
    end
    commit(4'd2);
    drain("stall_release");
`endif
    check_count("fwd_end_count", 3'd0);
  endtask

  task automatic test_queue_full;
    for (int i = 0; i < 4; i++)
      send(ST, 4'(6 + i), 16'(16'h0040 + i), 16'(16'h4000 + i), 16'(16'h4000 + i), 1'b1, 1'b1);
    checks++;
    if (lsu_full !== 1'b1) begin
      errors++;
      $display("FAIL full_flag: got lsu_full=%b, required 1", lsu_full);
    end
    drain("full_stores");
    check_count("full_count", 3'd4);
    in_valid = 1'b1; in_opcode = ST; in_rob_idx = 4'd10; in_a = 16'h0048; in_b = 16'hDEAD;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check_count("full_reject", 3'd4);
    commit(4'd7);
    check_count("commit_mismatch", 3'd4);
    commit(4'd6);
    check_count("commit_head", 3'd3);
    checks++;
    if (lsu_full !== 1'b0) begin
      errors++;
      $display("FAIL full_release: got lsu_full=%b, required 0", lsu_full);
    end
    commit(4'd7); commit(4'd8); commit(4'd9);
    check_count("full_empty", 3'd0);
    send(LD, 4'd11, 16'h0042, 16'h0000, 16'h4002, 1'b1, 1'b1);
    drain("full_load");
  endtask

  task automatic test_wrap;
    int   max_cnt = 0;
    exp_t e;
    for (int t = 0; t < 13; t++) begin
      in_valid = (t < 10);
      in_opcode = ST; in_rob_idx = 4'(t); in_a = 16'(16'h0060 + t); in_b = 16'(16'hC000 + t * 16'h0111);
      commit_valid = (t >= 3); commit_rob_idx = 4'(t - 3);
      @(negedge clk);
      if (t < 10) begin
        checks++;
        if (lsu_full !== 1'b0) begin
          errors++;
          $display("FAIL wrap_accept: got lsu_full=%b at step %0d, required 0", lsu_full, t);
        end else begin
          e.rob = 4'(t); e.val = 16'(16'hC000 + t * 16'h0111); e.cyc = cyc + 3; e.chk = 1'b1;
          sb_q.push_back(e);
        end
      end
      if (int'(sq_count) > max_cnt) max_cnt = int'(sq_count);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; commit_valid = 1'b0;
    checks++;
    if (max_cnt > 2) begin
      errors++;
      $display("FAIL wrap_max_count: got %0d, required at most 2", max_cnt);
    end
    check_count("wrap_end_count", 3'd0);
    drain("wrap_stores");
    for (int i = 0; i < 10; i++)
      send(LD, 4'(i), 16'(16'h0060 + i), 16'h0000, 16'(16'hC000 + i * 16'h0111), 1'b1, 1'b1);
    drain("wrap_loads");
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_commit();
    test_store_fwd();
    test_queue_full();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
